// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial subtractor sequencer: one borrow cell reused
// LSB-first over WIDTH cycles, valid/ready on both sides.
//
// Ports:
//   clk, rst        : rising-edge clock, sync active-high reset
//   in_valid/ready  : operand handshake (ready only in IDLE)
//   a, b            : WIDTH-bit unsigned minuend/subtrahend
//   out_valid/ready : result handshake (valid only in DONE)
//   difference      : (a - b) mod 2^WIDTH
//   borrow          : final borrow-out, 1 when a < b
//   zero            : difference == 0, qualified by out_valid
//   busy            : state != IDLE
module serial_subtractor_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] difference,
  output logic             borrow,
  output logic             zero,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t state;
  state_t state_n;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] diff_q;
  logic             brw_q;
  logic [CW-1:0]    cnt;

  logic ai;
  logic bi;
  logic di;
  logic bo;
  logic last;

  // Operands shift right each cycle, so the current bit is
  // always at position 0 and no variable index is needed.
  always_comb begin
    ai   = a_q[0];
    bi   = b_q[0];
    di   = ai ^ bi ^ brw_q;
    bo   = (~ai & bi) | (~(ai ^ bi) & brw_q);
    last = (cnt == LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_n = SHIFT;
      end
      SHIFT: begin
        if (last) state_n = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      diff_q <= '0;
      brw_q  <= 1'b0;
      cnt    <= '0;
    end else if (state == IDLE && in_valid) begin
      a_q    <= a;
      b_q    <= b;
      diff_q <= '0;
      brw_q  <= 1'b0;
      cnt    <= '0;
    end else if (state == SHIFT) begin
      a_q    <= a_q >> 1;
      b_q    <= b_q >> 1;
      diff_q <= diff_q | (WIDTH'(di) << cnt);
      brw_q  <= bo;
      // Hold at the last index so the count never leaves range.
      if (!last) cnt <= cnt + CW'(1);
    end
  end

  assign difference = diff_q;
  assign borrow     = brw_q;
  assign zero       = out_valid & (diff_q == '0);

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Bench for serial_subtractor_ctrl: WIDTH=8 and WIDTH=2
// instances checked against an arithmetic reference.
module tb_serial_subtractor_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic       iv8, ir8, ov8, or8, br8, z8, bz8;
  logic [7:0] a8, b8, d8;

  logic       iv2, ir2, ov2, or2, br2, z2, bz2;
  logic [1:0] a2, b2, d2;

  int passed = 0;
  int total  = 0;

  serial_subtractor_ctrl #(.WIDTH(8)) dut8 (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (iv8),
    .in_ready   (ir8),
    .a          (a8),
    .b          (b8),
    .out_valid  (ov8),
    .out_ready  (or8),
    .difference (d8),
    .borrow     (br8),
    .zero       (z8),
    .busy       (bz8)
  );

  serial_subtractor_ctrl #(.WIDTH(2)) dut2 (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (iv2),
    .in_ready   (ir2),
    .a          (a2),
    .b          (b2),
    .out_valid  (ov2),
    .out_ready  (or2),
    .difference (d2),
    .borrow     (br2),
    .zero       (z2),
    .busy       (bz2)
  );

  // Reference: plain integer subtraction, truncated.
  function automatic logic [7:0] ref_d8(input int x, input int y);
    int r;
    r = (x - y) & 255;
    return r[7:0];
  endfunction

  function automatic logic [1:0] ref_d2(input int x, input int y);
    int r;
    r = (x - y) & 3;
    return r[1:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one pair, wait for out_valid; lat = edges
  // from accept edge to out_valid (-1 on timeout).
  task automatic op8(input logic [7:0] x, input logic [7:0] y,
                     output int lat);
    a8 = x; b8 = y; iv8 = 1'b1;
    tick();
    iv8 = 1'b0;
    lat = 0;
    while (!ov8 && lat < 40) begin
      tick();
      lat++;
    end
    if (!ov8) lat = -1;
  endtask

  task automatic op2(input logic [1:0] x, input logic [1:0] y,
                     output int lat);
    a2 = x; b2 = y; iv2 = 1'b1;
    tick();
    iv2 = 1'b0;
    lat = 0;
    while (!ov2 && lat < 40) begin
      tick();
      lat++;
    end
    if (!ov2) lat = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    iv8 = 1'b0; or8 = 1'b1; a8 = '0; b8 = '0;
    iv2 = 1'b0; or2 = 1'b1; a2 = '0; b2 = '0;
    tick();
    tick();
    total++;
    if ({ir8, ov8, d8, br8, z8, bz8} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0})
      $display("FAIL reset8: got ir=%b ov=%b d=%h br=%b z=%b bz=%b",
               ir8, ov8, d8, br8, z8, bz8);
    else passed++;
    total++;
    if ({ir2, ov2, d2, br2, z2, bz2} !== {1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0})
      $display("FAIL reset2: got ir=%b ov=%b d=%h br=%b z=%b bz=%b",
               ir2, ov2, d2, br2, z2, bz2);
    else passed++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int lat;
    or8 = 1'b1;
    op8(8'h05, 8'h03, lat);
    total++;
    if (lat !== 8) $display("FAIL basic_lat: got %0d want 8", lat);
    else passed++;
    total++;
    if ({d8, br8, z8} !== {8'h02, 1'b0, 1'b0})
      $display("FAIL basic_res: got d=%h br=%b z=%b want 02 0 0", d8, br8, z8);
    else passed++;
    tick();
    total++;
    if ({ov8, ir8} !== 2'b01)
      $display("FAIL basic_pulse: got ov=%b ir=%b want 0 1", ov8, ir8);
    else passed++;
  endtask

  task automatic test_pairs();
    int lat;
    op8(8'h03, 8'h05, lat);
    total++;
    if ({d8, br8, z8} !== {8'hFE, 1'b1, 1'b0} || lat !== 8)
      $display("FAIL neg: got d=%h br=%b z=%b lat=%0d want fe 1 0 8",
               d8, br8, z8, lat);
    else passed++;
    tick();
    op8(8'h00, 8'h00, lat);
    total++;
    if ({d8, br8, z8} !== {8'h00, 1'b0, 1'b1} || lat !== 8)
      $display("FAIL zero: got d=%h br=%b z=%b lat=%0d want 00 0 1 8",
               d8, br8, z8, lat);
    else passed++;
    tick();
    total++;
    if (z8 !== 1'b0)
      $display("FAIL zero_qual: got z=%b want 0 when idle", z8);
    else passed++;
  endtask

  task automatic test_backpressure();
    int lat;
    int bad;
    or8 = 1'b0;
    op8(8'hA5, 8'h5A, lat);
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      if ({ov8, ir8, d8, br8} !== {1'b1, 1'b0, 8'h4B, 1'b0}) bad++;
      tick();
    end
    total++;
    if (bad != 0 || {ov8, d8, br8} !== {1'b1, 8'h4B, 1'b0})
      $display("FAIL backpressure: bad=%0d ov=%b d=%h br=%b want 0 1 4b 0",
               bad, ov8, d8, br8);
    else passed++;
    or8 = 1'b1;
    tick();
    total++;
    if ({ov8, ir8} !== 2'b01)
      $display("FAIL bp_release: got ov=%b ir=%b want 0 1", ov8, ir8);
    else passed++;
  endtask

  task automatic test_busy_ignore();
    int n;
    int bad;
    a8 = 8'h10; b8 = 8'h01; iv8 = 1'b1;
    tick();
    a8 = 8'hFF; b8 = 8'hFF;
    n = 0; bad = 0;
    while (!ov8 && n < 40) begin
      if (ir8 !== 1'b0) bad++;
      tick();
      n++;
    end
    total++;
    if ({d8, br8} !== {8'h0F, 1'b0} || n !== 8 || bad != 0)
      $display("FAIL busy_first: got d=%h br=%b n=%0d bad=%0d want 0f 0 8 0",
               d8, br8, n, bad);
    else passed++;
    tick();
    total++;
    if (ir8 !== 1'b1) $display("FAIL busy_idle: got ir=%b want 1", ir8);
    else passed++;
    tick();
    iv8 = 1'b0;
    n = 0;
    while (!ov8 && n < 40) begin
      tick();
      n++;
    end
    total++;
    if ({d8, br8, z8} !== {8'h00, 1'b0, 1'b1} || n !== 8)
      $display("FAIL busy_second: got d=%h br=%b z=%b n=%0d want 00 0 1 8",
               d8, br8, z8, n);
    else passed++;
    tick();
  endtask

  task automatic test_reset_mid();
    int pulses;
    int lat;
    a8 = 8'h80; b8 = 8'h01; iv8 = 1'b1;
    tick();
    iv8 = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if ({ir8, ov8, d8, br8, bz8} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0})
      $display("FAIL rst_mid: got ir=%b ov=%b d=%h br=%b bz=%b",
               ir8, ov8, d8, br8, bz8);
    else passed++;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      if (ov8) pulses++;
      tick();
    end
    total++;
    if (pulses != 0)
      $display("FAIL rst_nopulse: got %0d pulses want 0", pulses);
    else passed++;
    op8(8'h80, 8'h01, lat);
    total++;
    if ({d8, br8} !== {8'h7F, 1'b0} || lat !== 8)
      $display("FAIL rst_after: got d=%h br=%b lat=%0d want 7f 0 8",
               d8, br8, lat);
    else passed++;
    tick();
  endtask

  task automatic test_random();
    int lat;
    int hold;
    int bad;
    logic [7:0] x, y, ed;
    logic eb;
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      x = 8'($urandom);
      y = 8'($urandom);
      if (k == 0) begin x = 8'hFF; y = 8'h00; end
      if (k == 1) begin x = 8'h00; y = 8'hFF; end
      ed = ref_d8(int'(x), int'(y));
      eb = (x < y);
      hold = $urandom_range(0, 3);
      or8 = (hold == 0);
      op8(x, y, lat);
      total++;
      if ({d8, br8, z8} !== {ed, eb, ed == 8'h00} || lat !== 8)
        $display("FAIL rand %h-%h: got d=%h br=%b z=%b lat=%0d want %h %b %b 8",
                 x, y, d8, br8, z8, lat, ed, eb, ed == 8'h00);
      else passed++;
      for (int i = 0; i < hold; i++) begin
        tick();
        if ({ov8, d8, br8} !== {1'b1, ed, eb}) bad++;
      end
      or8 = 1'b1;
      tick();
      if (ov8 !== 1'b0) bad++;
    end
    total++;
    if (bad != 0) $display("FAIL rand_hold: got %0d bad cycles want 0", bad);
    else passed++;
  endtask

  task automatic test_w2_exhaustive();
    int lat;
    logic [1:0] x, y, ed;
    logic eb;
    or2 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        x = 2'(i);
        y = 2'(j);
        ed = ref_d2(i, j);
        eb = (i < j);
        op2(x, y, lat);
        total++;
        if ({d2, br2, z2} !== {ed, eb, ed == 2'b00} || lat !== 2)
          $display("FAIL w2 %b-%b: got d=%b br=%b z=%b lat=%0d want %b %b 2",
                   x, y, d2, br2, z2, lat, ed, eb);
        else passed++;
        tick();
      end
    end
    op2(2'b11, 2'b01, lat);
    total++;
    if ({d2, br2} !== {2'b10, 1'b0})
      $display("FAIL w2_spot1: got d=%b br=%b want 10 0", d2, br2);
    else passed++;
    tick();
    op2(2'b01, 2'b11, lat);
    total++;
    if ({d2, br2} !== {2'b10, 1'b1})
      $display("FAIL w2_spot2: got d=%b br=%b want 10 1", d2, br2);
    else passed++;
    tick();
    op2(2'b00, 2'b01, lat);
    total++;
    if ({d2, br2} !== {2'b11, 1'b1} || lat !== 2)
      $display("FAIL w2_spot3: got d=%b br=%b lat=%0d want 11 1 2",
               d2, br2, lat);
    else passed++;
    tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_pairs();
    test_backpressure();
    test_busy_ignore();
    test_reset_mid();
    test_random();
    test_w2_exhaustive();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
